seg7_to_binary: RTL
===================

// Module: seg7_to_binary
// PURPOSE
//  Reads back three active-low 7-segment digit patterns (hundreds, tens, ones) and
//  recovers the BCD digits and the binary value they show, 0..999. It performs the
//  inverse of the binary->BCD->7-seg display encoder. The game logic uses it to
//  compare or score values taken from HEX display buses.
//  Conversion is a multi-cycle reverse double-dabble controlled by a start/busy/done handshake.
// PARAMETERS
//  BIN_W       10  binary result width and shift-iteration count; must be >= 10
//  BLANK_ZERO  1   1: blank pattern 7'b1111111 decodes as digit 0; 0: blank sets err
// PORTS
//  clk     in   1      system clock, rising edge
//  rst     in   1      reset, asynchronous, active-low
//  start   in   1      request; sampled only in IDLE
//  seg_h   in   7      hundreds pattern, active-low {g,f,e,d,c,b,a}
//  seg_t   in   7      tens pattern
//  seg_o   in   7      ones pattern
//  busy    out  1      high while a conversion is in progress
//  done    out  1      one-cycle pulse; value/bcd/err valid from this cycle
//  err     out  1      last conversion hit an illegal pattern
//  value   out  BIN_W  binary result
//  bcd     out  12     {hundreds,tens,ones} BCD digits of last conversion
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; busy=0, done=0, err=0, value=0, bcd=0; counters cleared.
//  Decode table (pattern->digit): 1000000:0 1111001:1 0100100:2 0110000:3 0011001:4
//   0010010:5 0000010:6 1111000:7 0000000:8 0011000:9; blank per BLANK_ZERO;
//   any other pattern is illegal.
//  FSM: IDLE -> DECODE -> CONV -> FINISH -> IDLE. busy = (state != IDLE), registered.
//  Edge N: IDLE with start=1 captures seg_h/seg_t/seg_o into regs; state<=DECODE.
//   Inputs are not sampled again until the next accepted start.
//  Edge N+1 DECODE: decode the captured patterns, load bcd_sh<=digits, bin_sh<=0, cnt<=0.
//   Any illegal digit: err_pend<=1, state<=FINISH. Otherwise state<=CONV.
//  Edges N+2..N+11 CONV (BIN_W steps): {bcd_sh,bin_sh} <= {bcd_sh,bin_sh} >> 1.
//   Then, for each nibble of the shifted bcd_sh, if nibble >= 8 subtract 3.
//   cnt++; after the step with cnt==BIN_W-1, state<=FINISH.
//  Edge N+12 FINISH (N+2 on error): done<=1, value<=bin_sh (0 on error),
//   bcd<=decoded digits (0 on error), err<=err_pend; state<=IDLE.
//  done clears at the next edge. value/bcd/err hold until the next FINISH.
//  start while busy (DECODE/CONV/FINISH): ignored, not queued.
//  start held high continuously: a new conversion begins on the first IDLE edge after done.
//  Result is independent of seg_* changes after edge N.
//  rst low mid-conversion aborts immediately to reset values; no done pulse follows.
//  All arithmetic is unsigned. Nibble subtract-3 is applied only when nibble >= 8, so it never underflows.
// TESTING
//  1 seg_h=1111001,seg_t=0100100,seg_o=0110000, start pulse edge N
//    -> busy 1 from N..N+11; done at N+12; value=123, bcd=12'h123, err=0.
//  2 seg 9,9,9 (0011000 x3) -> value=999 (10'h3E7), bcd=12'h999, err=0, latency 12.
//  3 BLANK_ZERO=1, seg_h=seg_t=1111111, seg_o=1111000 -> value=7, bcd=12'h007, err=0.
//    Same with BLANK_ZERO=0 -> err=1, value=0, done at N+2.
//  4 seg_t=0101010 (illegal), others valid -> done at N+2, err=1, value=0, bcd=0.
//    A following legal conversion clears err.
//  5 Convert 456, then change seg_* to 8,8,8 and pulse start at N+3 and N+7
//    -> single done at N+12, value=456; next start in IDLE converts 888.
//  6 rst=0 at N+6 mid-CONV -> busy/done/err/value/bcd=0 immediately, no done pulse.
//    After release, start converts 0,0,0 -> value=0, done at +12.

Source files
------------

// File: rtl/seg7_to_binary_if.sv
// Handshake and data bundle for the 7-segment read-back converter.
// The requester drives start and the three digit patterns; the converter returns status and results.
interface seg7_to_binary_if #(
    parameter int unsigned BIN_W = 10
);
    logic             start;
    logic [6:0]       seg_h;
    logic [6:0]       seg_t;
    logic [6:0]       seg_o;
    logic             busy;
    logic             done;
    logic             err;
    logic [BIN_W-1:0] value;
    logic [11:0]      bcd;

    modport master (
        output start, seg_h, seg_t, seg_o,
        input  busy, done, err, value, bcd
    );

    modport slave (
        input  start, seg_h, seg_t, seg_o,
        output busy, done, err, value, bcd
    );
endinterface

// File: rtl/seg7_to_binary.sv
// Recovers BCD digits and the binary value 0..999 from three active-low 7-segment patterns
// using a multi-cycle reverse double-dabble behind a start/busy/done handshake.
module seg7_to_binary #(
    parameter int unsigned BIN_W      = 10,
    parameter bit          BLANK_ZERO = 1'b1
) (
    input logic              clk,
    input logic              rst,
    seg7_to_binary_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {IDLE, DECODE, CONV, FINISH} state_t;

    // Returns {illegal, digit} for one active-low {g,f,e,d,c,b,a} pattern.
    function automatic logic [4:0] dec7(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1000000: r = 5'd0;
            7'b1111001: r = 5'd1;
            7'b0100100: r = 5'd2;
            7'b0110000: r = 5'd3;
            7'b0011001: r = 5'd4;
            7'b0010010: r = 5'd5;
            7'b0000010: r = 5'd6;
            7'b1111000: r = 5'd7;
            7'b0000000: r = 5'd8;
            7'b0011000: r = 5'd9;
            7'b1111111: r = BLANK_ZERO ? 5'b0_0000 : 5'b1_0000;
            default:    r = 5'b1_0000;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [6:0]       seg_h_q, seg_h_d;
    logic [6:0]       seg_t_q, seg_t_d;
    logic [6:0]       seg_o_q, seg_o_d;
    logic [11:0]      digits_q, digits_d;
    logic [11:0]      bcd_sh_q, bcd_sh_d;
    logic [BIN_W-1:0] bin_sh_q, bin_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_pend_q, err_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [BIN_W-1:0] value_q, value_d;
    logic [11:0]      bcd_q, bcd_d;

    logic [4:0]       dec_h, dec_t, dec_o;

    assign dec_h = dec7(seg_h_q);
    assign dec_t = dec7(seg_t_q);
    assign dec_o = dec7(seg_o_q);

    always_comb begin
        state_d    = state_q;
        seg_h_d    = seg_h_q;
        seg_t_d    = seg_t_q;
        seg_o_d    = seg_o_q;
        digits_d   = digits_q;
        bcd_sh_d   = bcd_sh_q;
        bin_sh_d   = bin_sh_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        err_d      = err_q;
        value_d    = value_q;
        bcd_d      = bcd_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    seg_h_d = bus.seg_h;
                    seg_t_d = bus.seg_t;
                    seg_o_d = bus.seg_o;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                digits_d   = {dec_h[3:0], dec_t[3:0], dec_o[3:0]};
                bcd_sh_d   = {dec_h[3:0], dec_t[3:0], dec_o[3:0]};
                bin_sh_d   = '0;
                cnt_d      = '0;
                err_pend_d = dec_h[4] | dec_t[4] | dec_o[4];
                state_d    = (dec_h[4] | dec_t[4] | dec_o[4]) ? FINISH : CONV;
            end
            CONV: begin
                // One reverse double-dabble step: shift right, then undo the +3 correction per digit.
                {bcd_sh_d, bin_sh_d} = {bcd_sh_q, bin_sh_q} >> 1;
                for (int unsigned i = 0; i < 3; i++) begin
                    if (bcd_sh_d[4*i+3]) begin
                        bcd_sh_d[4*i +: 4] = bcd_sh_d[4*i +: 4] - 4'd3;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                err_d   = err_pend_q;
                value_d = err_pend_q ? '0 : bin_sh_q;
                bcd_d   = err_pend_q ? '0 : digits_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            seg_h_q    <= '0;
            seg_t_q    <= '0;
            seg_o_q    <= '0;
            digits_q   <= '0;
            bcd_sh_q   <= '0;
            bin_sh_q   <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            value_q    <= '0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            seg_h_q    <= seg_h_d;
            seg_t_q    <= seg_t_d;
            seg_o_q    <= seg_o_d;
            digits_q   <= digits_d;
            bcd_sh_q   <= bcd_sh_d;
            bin_sh_q   <= bin_sh_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            value_q    <= value_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.value = value_q;
    assign bus.bcd   = bcd_q;
endmodule
